affine_alu_seq: RTL and testbench
=================================

Name: affine_alu_seq

Overview:
- Multi-cycle controller that computes a 2-D affine transform on the shared picoMIPS ALU:
  - x' = c0*x + c1*y + e0
  - y' = c2*x + c3*y + e1
- All operands are signed n-bit values. Coefficients are Q1.7, so MUL returns product bits [14:7].
- The block issues one ALU operation per granted cycle and captures the ALU result on the next edge.
- It sits beside the instruction datapath and arbitrates for the ALU with req/gnt.

Parameters:
- n, 8, datapath width of operands, coefficients and results.

Ports:
- clk  in  1  system clock, rising-edge.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- x_in, y_in  in  n each  signed input point.
- c0, c1, c2, c3  in  n each  signed Q1.7 coefficients.
- e0, e1  in  n each  signed offsets.
- busy  out  1  high from the cycle after start is accepted until done deasserts.
- done  out  1  one-cycle pulse when x_out/y_out are updated.
- x_out, y_out  out  n each  signed results; held until the next done.
- x_zero, y_zero  out  1 each  zero flag of the final ADD for x and for y.
- alu_req  out  1  ALU ownership request.
- alu_gnt  in  1  ALU granted this cycle.
- alu_a, alu_b  out  n each  ALU operands.
- alu_func  out  3  ALU function, RADD or RMUL encoding from alucodes.sv.
- alu_result  in  n  combinational ALU result.
- alu_zero  in  1  ALU flags[1].

Behaviour:
- Reset (async, nreset=0):
  - state=IDLE, step=0.
  - busy, done, alu_req, x_zero, y_zero = 0.
  - x_out, y_out, acc, tmp = 0.
  - alu_a, alu_b = 0; alu_func = RADD.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On a clock edge with start=1, latch x_in, y_in, c0..c3, e0, e1 into internal registers, set step=0, go to RUN.
  - Later input changes have no effect.
- RUN:
  - alu_req=1 and busy=1.
  - alu_a, alu_b, alu_func are decoded combinationally from step and the latched registers.
  - Step sequence:
    - 0: RMUL c0,x -> acc
    - 1: RMUL c1,y -> tmp
    - 2: RADD acc,tmp -> acc
    - 3: RADD acc,e0 -> x result and x_zero
    - 4: RMUL c2,x -> acc
    - 5: RMUL c3,y -> tmp
    - 6: RADD acc,tmp -> acc
    - 7: RADD acc,e1 -> y result and y_zero
  - Capture and step+1 happen only on edges where alu_gnt=1.
  - If alu_gnt=0: no capture, step holds, alu_a/alu_b/alu_func stay stable, alu_req stays high.
  - After the edge that captures step 7, go to DONE.
  - The x result is staged internally. x_out and y_out update together at that edge, so the outputs never show a half-updated pair.
- DONE:
  - done=1 and busy=1 for exactly one cycle; alu_req=0.
  - Next state is IDLE.
- Latency: with alu_gnt held high, done is high in the 9th cycle after the start-sampling edge (8 RUN cycles + 1).
- Start handling: start while not in IDLE is ignored, not queued. Back-to-back transforms are possible: start may be sampled in the first IDLE cycle after DONE.
- Arithmetic:
  - Two's-complement wrap exactly as the ALU produces it; no saturation in the sequencer.
  - The zero flags come from alu_zero at the capturing edge.
- Reset mid-operation: immediate abort to the reset state. Outputs clear and no done is produced.
- The block never drives the ALU meaningfully outside RUN. alu_req=0 in IDLE and DONE.

Test Plan:
- Basic: c0=c1=c2=c3=0x40, e0=5, e1=-3, x=64, y=32, gnt=1 -> after 9 cycles done=1, x_out=53, y_out=45, zero flags 0.
- Negative coefficients: c0=0x80 (-1.0), c1=0, e0=0, x=10 -> x_out=0xF6 (-10). Same with c2=0x80, c3=0, e1=10 -> y_out=0, y_zero=1.
- Wrap: c0=c1=0x40, x=y=127, e0=10 -> x_out=0x88 (-120), no saturation.
- Stall: drop gnt for 3 cycles during step 2 and 2 cycles during step 6 -> operands and func stable while gnt=0, done at cycle 14, results identical to the no-stall run.
- Start ignored while busy; input changes after acceptance ignored: pulse start again at step 4 and change x_in -> single done, results from the originally latched operands.
- Reset at step 5 -> all outputs 0 immediately, no done. A following start completes a fresh transform correctly.

Source files
------------

// File: rtl/affine_alu_seq_if.sv
// ALU ownership bus between the affine sequencer (master) and the shared
// picoMIPS ALU with its arbiter (slave).
//
// Handshake: alu_req acts as valid and alu_gnt as ready. An operation
// transfers on a rising clk edge where both are high. While alu_req is high
// and alu_gnt is low, alu_a/alu_b/alu_func must hold steady. alu_result and
// alu_zero are combinational functions of the operands and are sampled on
// the transferring edge.
interface affine_alu_seq_if #(
  parameter int n = 8
);
  logic         alu_req;
  logic         alu_gnt;
  logic [n-1:0] alu_a;
  logic [n-1:0] alu_b;
  logic [2:0]   alu_func;
  logic [n-1:0] alu_result;
  logic         alu_zero;

  modport master (
    output alu_req, alu_a, alu_b, alu_func,
    input  alu_gnt, alu_result, alu_zero
  );

  modport slave (
    input  alu_req, alu_a, alu_b, alu_func,
    output alu_gnt, alu_result, alu_zero
  );
endinterface

// File: rtl/affine_alu_seq.sv
// Multi-cycle affine transform sequencer on the shared ALU:
//   x' = c0*x + c1*y + e0,  y' = c2*x + c3*y + e1  (coefficients Q1.7).
// One ALU operation per granted cycle; the result is captured on that edge.
module affine_alu_seq #(
  parameter int n = 8
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                start,
  input  logic [n-1:0]        x_in,
  input  logic [n-1:0]        y_in,
  input  logic [n-1:0]        c0,
  input  logic [n-1:0]        c1,
  input  logic [n-1:0]        c2,
  input  logic [n-1:0]        c3,
  input  logic [n-1:0]        e0,
  input  logic [n-1:0]        e1,
  output logic                busy,
  output logic                done,
  output logic [n-1:0]        x_out,
  output logic [n-1:0]        y_out,
  output logic                x_zero,
  output logic                y_zero,
  affine_alu_seq_if.master    alu,
  output logic [1:0]          dbg_state,
  output logic [2:0]          dbg_step
);

  // ALU function codes (picoMIPS alucodes encoding)
  localparam logic [2:0] RADD = 3'b010;
  localparam logic [2:0] RMUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nx;
  logic [2:0]   step;
  logic [n-1:0] x_r, y_r, c0_r, c1_r, c2_r, c3_r, e0_r, e1_r;
  logic [n-1:0] acc, tmp;
  logic [n-1:0] x_stage;
  logic         xz_stage;
  logic         fire;

  // An operation completes on edges where we own the ALU and it is granted
  assign fire      = (state == RUN) && alu.alu_gnt;
  assign dbg_state = state;
  assign dbg_step  = step;

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state, status outputs and step-decoded ALU operands
  always_comb begin
    state_nx     = state;
    busy         = 1'b0;
    done         = 1'b0;
    alu.alu_req  = 1'b0;
    alu.alu_a    = '0;
    alu.alu_b    = '0;
    alu.alu_func = RADD;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy        = 1'b1;
        alu.alu_req = 1'b1;
        unique case (step)
          3'd0: begin alu.alu_a = c0_r; alu.alu_b = x_r;  alu.alu_func = RMUL; end
          3'd1: begin alu.alu_a = c1_r; alu.alu_b = y_r;  alu.alu_func = RMUL; end
          3'd2: begin alu.alu_a = acc;  alu.alu_b = tmp;  alu.alu_func = RADD; end
          3'd3: begin alu.alu_a = acc;  alu.alu_b = e0_r; alu.alu_func = RADD; end
          3'd4: begin alu.alu_a = c2_r; alu.alu_b = x_r;  alu.alu_func = RMUL; end
          3'd5: begin alu.alu_a = c3_r; alu.alu_b = y_r;  alu.alu_func = RMUL; end
          3'd6: begin alu.alu_a = acc;  alu.alu_b = tmp;  alu.alu_func = RADD; end
          default: begin alu.alu_a = acc; alu.alu_b = e1_r; alu.alu_func = RADD; end
        endcase
        if (alu.alu_gnt && step == 3'd7) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latching on start, result capture on granted edges
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      step     <= '0;
      x_r      <= '0;
      y_r      <= '0;
      c0_r     <= '0;
      c1_r     <= '0;
      c2_r     <= '0;
      c3_r     <= '0;
      e0_r     <= '0;
      e1_r     <= '0;
      acc      <= '0;
      tmp      <= '0;
      x_stage  <= '0;
      xz_stage <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      x_zero   <= 1'b0;
      y_zero   <= 1'b0;
    end else if (state == IDLE && start) begin
      step <= '0;
      x_r  <= x_in;
      y_r  <= y_in;
      c0_r <= c0;
      c1_r <= c1;
      c2_r <= c2;
      c3_r <= c3;
      e0_r <= e0;
      e1_r <= e1;
    end else if (fire) begin
      step <= step + 3'd1;
      unique case (step)
        3'd0, 3'd2, 3'd4, 3'd6: acc <= alu.alu_result;
        3'd1, 3'd5:             tmp <= alu.alu_result;
        3'd3: begin
          // x result waits here so both outputs change on the same edge
          x_stage  <= alu.alu_result;
          xz_stage <= alu.alu_zero;
        end
        default: begin
          x_out  <= x_stage;
          x_zero <= xz_stage;
          y_out  <= alu.alu_result;
          y_zero <= alu.alu_zero;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_affine_alu_seq.sv
// Bench for affine_alu_seq: behavioural ALU, transform model, scoreboard.
module tb_affine_alu_seq;
  localparam int N = 8;
  localparam logic [2:0] RADD = 3'b010;
  localparam logic [2:0] RMUL = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nreset;

  logic         start;
  logic [N-1:0] x_in, y_in, c0, c1, c2, c3, e0, e1;
  logic         busy, done, x_zero, y_zero;
  logic [N-1:0] x_out, y_out;
  logic [1:0]   dbg_state;
  logic [2:0]   dbg_step;

  affine_alu_seq_if #(.n(N)) alu_bus ();

  affine_alu_seq #(.n(N)) dut (
    .clk(clk), .nreset(nreset), .start(start),
    .x_in(x_in), .y_in(y_in), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .e0(e0), .e1(e1), .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .x_zero(x_zero), .y_zero(y_zero),
    .alu(alu_bus), .dbg_state(dbg_state), .dbg_step(dbg_step)
  );

  // Shared ALU behaviour: ADD wraps, MUL returns product bits [14:7]
  logic signed [15:0] alu_prod;
  always_comb begin
    alu_prod = $signed(alu_bus.alu_a) * $signed(alu_bus.alu_b);
    if (alu_bus.alu_func == RMUL) alu_bus.alu_result = alu_prod[14:7];
    else                          alu_bus.alu_result = alu_bus.alu_a + alu_bus.alu_b;
    alu_bus.alu_zero = (alu_bus.alu_result == '0);
  end

  // ---------------- counters / check ----------------
  int pass_cnt = 0;
  int check_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int qmul(input logic [N-1:0] c, input logic [N-1:0] v);
    int p;
    p = int'($signed(c)) * int'($signed(v));
    return p >>> 7;
  endfunction

  // returns {x', y', x_zero, y_zero}
  function automatic logic [17:0] model(input logic [N-1:0] x, y, k0, k1, k2, k3, f0, f1);
    logic [N-1:0] xr, yr;
    xr = 8'(qmul(k0, x) + qmul(k1, y) + int'($signed(f0)));
    yr = 8'(qmul(k2, x) + qmul(k3, y) + int'($signed(f1)));
    return {xr, yr, xr == 8'd0, yr == 8'd0};
  endfunction

  function automatic logic stall_at(input logic [63:0] m, input int i);
    return (i < 64) ? m[i] : 1'b0;
  endfunction

  // cycle (counted from the start edge) in which done must appear
  function automatic int exp_latency(input logic [63:0] m);
    int g;
    g = 0;
    for (int i = 1; i < 200; i++) begin
      if (!stall_at(m, i)) g++;
      if (g == 8) return i + 1;
    end
    return -1;
  endfunction

  // ---------------- scoreboard ----------------
  logic [17:0]  exp_q[$];
  logic [17:0]  held;
  logic [N-1:0] ops_a[8], ops_b[8];
  int           op_idx;
  logic         chk_en;
  logic         prev_stall;
  logic [N-1:0] prev_a, prev_b;
  logic [2:0]   prev_f;
  logic [17:0]  e_pop;

  // Compare process: results on done, held outputs otherwise, ALU bus each cycle
  always @(negedge clk) begin
    if (nreset && chk_en) begin
      if (done) begin
        check("done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_pop = exp_q.pop_front();
          check("x_out", x_out, e_pop[17:10]);
          check("y_out", y_out, e_pop[9:2]);
          check("x_zero", x_zero, e_pop[1]);
          check("y_zero", y_zero, e_pop[0]);
          held = e_pop;
        end
      end else begin
        check("outputs_held", {x_out, y_out, x_zero, y_zero}, held);
      end
      check("alu_req_in_run", alu_bus.alu_req, busy && !done);
      if (alu_bus.alu_req) begin
        check("alu_func", alu_bus.alu_func, (op_idx % 4 < 2) ? RMUL : RADD);
        if (op_idx % 4 < 2 && op_idx < 8) begin
          check("alu_a_mul", alu_bus.alu_a, ops_a[op_idx]);
          check("alu_b_mul", alu_bus.alu_b, ops_b[op_idx]);
        end
        if (prev_stall)
          check("stall_stable", {alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_func},
                {prev_a, prev_b, prev_f});
        prev_stall = !alu_bus.alu_gnt;
        prev_a = alu_bus.alu_a;
        prev_b = alu_bus.alu_b;
        prev_f = alu_bus.alu_func;
        if (alu_bus.alu_gnt) op_idx++;
      end else begin
        prev_stall = 1'b0;
        check("alu_idle_bus", {alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_func},
              {8'd0, 8'd0, RADD});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [N-1:0] x, y, k0, k1, k2, k3, f0, f1,
                        input logic [63:0] mask, input int restart_at, input int reset_at);
    int got, lat, extra;
    @(negedge clk);
    x_in = x; y_in = y; c0 = k0; c1 = k1; c2 = k2; c3 = k3; e0 = f0; e1 = f1;
    start = 1'b1;
    ops_a[0] = k0; ops_b[0] = x;
    ops_a[1] = k1; ops_b[1] = y;
    ops_a[4] = k2; ops_b[4] = x;
    ops_a[5] = k3; ops_b[5] = y;
    @(posedge clk); #1;
    start = 1'b0;
    op_idx = 0;
    exp_q.push_back(model(x, y, k0, k1, k2, k3, f0, f1));
    lat = exp_latency(mask);
    got = -1;
    for (int i = 1; i <= 80; i++) begin
      alu_bus.alu_gnt = !stall_at(mask, i);
      if (i == restart_at) begin
        start = 1'b1;
        x_in = ~x_in;
        y_in = y_in + 8'd1;
      end else begin
        start = 1'b0;
      end
      if (i == reset_at) begin
        nreset = 1'b0;
        #1;
        check("abort_clear", {busy, done, x_out, y_out, x_zero, y_zero, alu_bus.alu_req},
              '0);
        exp_q.delete();
        held = '0;
        @(negedge clk);
        #2 nreset = 1'b1;
        return;
      end
      @(negedge clk);
      if (done) begin
        got = i;
        check("busy_in_done", busy, 1);
        break;
      end
      check("busy_running", busy, 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("latency", got, lat);
    if (restart_at > 0) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("restart_ignored", extra, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] m;
    chk_en = 1'b0; held = '0; op_idx = 0; prev_stall = 1'b0;
    nreset = 1'b0; start = 1'b0; alu_bus.alu_gnt = 1'b0;
    x_in = '0; y_in = '0; c0 = '0; c1 = '0; c2 = '0; c3 = '0; e0 = '0; e1 = '0;
    #12;
    check("reset_outputs", {busy, done, x_out, y_out, x_zero, y_zero, alu_bus.alu_req}, '0);
    check("reset_alu_bus", {alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_func}, {16'd0, RADD});
    @(negedge clk); nreset = 1'b1;
    @(posedge clk); #1 chk_en = 1'b1;

    // hand-computed pins on the model
    check("model_basic", model(8'd64, 8'd32, 8'h40, 8'h40, 8'h40, 8'h40, 8'd5, 8'hFD),
          {8'd53, 8'd45, 1'b0, 1'b0});
    check("model_neg", model(8'd10, 8'd0, 8'h80, 8'h00, 8'h80, 8'h00, 8'd0, 8'd10),
          {8'hF6, 8'h00, 1'b0, 1'b1});
    check("model_wrap", model(8'd127, 8'd127, 8'h40, 8'h40, 8'h00, 8'h00, 8'd10, 8'd0),
          {8'h88, 8'h00, 1'b0, 1'b1});
    check("stall_latency_pin", exp_latency(64'h0C38), 14);

    // directed cases
    run_op(8'd64, 8'd32, 8'h40, 8'h40, 8'h40, 8'h40, 8'd5, 8'hFD, 64'h0, 0, 0);
    run_op(8'd10, 8'd0, 8'h80, 8'h00, 8'h80, 8'h00, 8'd0, 8'd10, 64'h0, 0, 0);
    run_op(8'd127, 8'd127, 8'h40, 8'h40, 8'h00, 8'h00, 8'd10, 8'd0, 64'h0, 0, 0);
    // grant dropped 3 cycles in step 2 and 2 cycles in step 6
    run_op(8'd64, 8'd32, 8'h40, 8'h40, 8'h40, 8'h40, 8'd5, 8'hFD, 64'h0C38, 0, 0);
    // second start during step 4 with altered inputs
    run_op(8'd64, 8'd32, 8'h40, 8'h40, 8'h40, 8'h40, 8'd5, 8'hFD, 64'h0, 5, 0);
    // reset during step 5, then a fresh transform
    run_op(8'd20, 8'd30, 8'h60, 8'h20, 8'hC0, 8'h10, 8'd7, 8'd9, 64'h0, 0, 6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_done_after_abort", done, 0);
    end
    @(posedge clk); #1;
    run_op(8'd20, 8'd30, 8'h60, 8'h20, 8'hC0, 8'h10, 8'd7, 8'd9, 64'h0, 0, 0);

    // randomized back-to-back transforms with random grant stalls
    for (int t = 0; t < 40; t++) begin
      m = {$urandom, $urandom} & {$urandom, $urandom};
      m[0] = 1'b0;
      if (t % 4 == 0) m = '0;
      run_op(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), m, 0, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, check_cnt + 1);
    $fatal(1, "timeout");
  end
endmodule
